// File: rtl/hls_deadlock_mon_pkg.sv
// hls_deadlock_mon_pkg
//   Shared types and helpers for the parametrised HLS dataflow deadlock monitor.
//   - state_e    : persistence FSM states
//   - HOLD_W     : width of the persistence window counter
//   - mask_slice : extracts one process's AXIS owner mask from the flattened map
package hls_deadlock_mon_pkg;

    localparam int HOLD_W   = 16;
    // Largest flattened owner map: 32 processes x 64 AXIS signals.
    localparam int MASK_MAX = 2048;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DETECTED = 2'd2
    } state_e;

    // Returns bits [p*n_axis +: n_axis] of the owner map, zero-extended to 64.
    // A shift is used instead of a variable bit index so the function stays
    // usable as a constant function at elaboration time.
    function automatic logic [63:0] mask_slice(input logic [MASK_MAX-1:0] mask,
                                               input int n_axis,
                                               input int p);
        logic [MASK_MAX-1:0] sh;
        logic [63:0]         low;
        sh  = mask >> (p * n_axis);
        low = (n_axis >= 64) ? {64{1'b1}} : ((64'd1 << n_axis) - 64'd1);
        return sh[63:0] & low;
    endfunction

endpackage

// File: rtl/hls_deadlock_param_monitor_persist.sv
// deadlock_persist_counter
//   Qualifies a candidate deadlock condition over HOLD_CYCLES consecutive
//   cycles before declaring it.
//   Ports:
//     clock_i  : rising-edge clock
//     reset_i  : synchronous active-low reset
//     cond_i   : candidate deadlock condition, sampled every cycle
//     block_o  : registered, high exactly while in DETECTED
//     enter_o  : combinational; high when the coming edge moves the FSM into
//                DETECTED (same edge on which block_o rises)
module deadlock_persist_counter
    import hls_deadlock_mon_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic cond_i,
    output logic block_o,
    output logic enter_o
);

    localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(HOLD_CYCLES);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cond_i) begin
                    cnt_d   = HOLD_W'(1);
                    state_d = (HOLD == HOLD_W'(1)) ? ST_DETECTED : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!cond_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                    if (cnt_q + HOLD_W'(1) == HOLD) state_d = ST_DETECTED;
                end
            end
            ST_DETECTED: begin
                if (!cond_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign block_o = (state_q == ST_DETECTED);
    assign enter_o = (state_d == ST_DETECTED) && (state_q != ST_DETECTED);

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// hls_deadlock_param_monitor
//   Dataflow deadlock monitor for N_PROC processes fed by N_AXIS AXIS block
//   signals. A deadlock candidate (every process stopped, at least one of them
//   on an AXIS stream) must persist HOLD_CYCLES cycles before block_o rises.
//   Ports:
//     clock_i            : rising-edge clock
//     reset_i            : synchronous active-low reset
//     axis_block_sigs_i  : per-stream AXIS blocked
//     inst_idle_sigs_i   : per-process idle
//     inst_block_sigs_i  : per-process blocked on internal channel
//     child_block_i      : qualifying block from nested monitor (1 if none)
//     clear_i            : pulse; clears sticky, snapshot and stall counter
//     block_o            : live qualified deadlock
//     block_sticky_o     : deadlock seen since last clear
//     block_proc_o       : axis-blocked processes captured on first detection
//     stall_cycles_o     : saturating count of cycles spent in DETECTED
//   Build option: DEADLOCK_MON_SNAPSHOT_EN enables block_proc_o and
//   stall_cycles_o; without it both are tied to zero.
module hls_deadlock_param_monitor
    import hls_deadlock_mon_pkg::*;
#(
    parameter int                       N_PROC      = 3,
    parameter int                       N_AXIS      = 12,
    parameter logic [N_PROC*N_AXIS-1:0] AXIS_MASK   = {N_PROC*N_AXIS{1'b0}},
    parameter int                       HOLD_CYCLES = 1,
    parameter int                       STALL_W     = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [N_AXIS-1:0]   axis_block_sigs_i,
    input  logic [N_PROC-1:0]   inst_idle_sigs_i,
    input  logic [N_PROC-1:0]   inst_block_sigs_i,
    input  logic [N_PROC-1:0]   child_block_i,
    input  logic                clear_i,
    output logic                block_o,
    output logic                block_sticky_o,
    output logic [N_PROC-1:0]   block_proc_o,
    output logic [STALL_W-1:0]  stall_cycles_o
);

    localparam logic [MASK_MAX-1:0] MASK_EXT = MASK_MAX'(AXIS_MASK);

    logic [N_PROC-1:0] axis_vec;
    logic [N_PROC-1:0] stop;
    logic              cond;
    logic              enter;
    logic              sticky_q, sticky_d;

    for (genvar p = 0; p < N_PROC; p++) begin : g_proc
        localparam logic [63:0]       M64 = mask_slice(MASK_EXT, N_AXIS, p);
        localparam logic [N_AXIS-1:0] M   = M64[N_AXIS-1:0];
        assign axis_vec[p] = child_block_i[p] & (|(axis_block_sigs_i & M));
        assign stop[p]     = inst_idle_sigs_i[p] | inst_block_sigs_i[p] | axis_vec[p];
    end

    assign cond = (|axis_vec) & (&stop);

    deadlock_persist_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_persist (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .cond_i  (cond),
        .block_o (block_o),
        .enter_o (enter)
    );

    // Sticky is also re-set while still DETECTED, so a clear issued mid-deadlock
    // drops it for only one cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (clear_i)              sticky_d = 1'b0;
        else if (enter || block_o) sticky_d = 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) sticky_q <= 1'b0;
        else          sticky_q <= sticky_d;
    end

    assign block_sticky_o = sticky_q;

`ifdef DEADLOCK_MON_SNAPSHOT_EN
    logic [N_PROC-1:0]  proc_q, proc_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // Snapshot only the first detection since the last clear; later entries
    // keep the original blame vector for debug.
    always_comb begin
        proc_d  = proc_q;
        stall_d = stall_q;
        if (clear_i) begin
            proc_d  = '0;
            stall_d = '0;
        end else begin
            if (enter && !sticky_q)          proc_d  = axis_vec;
            if (block_o && (stall_q != '1))  stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            proc_q  <= '0;
            stall_q <= '0;
        end else begin
            proc_q  <= proc_d;
            stall_q <= stall_d;
        end
    end

    assign block_proc_o   = proc_q;
    assign stall_cycles_o = stall_q;
`else
    assign block_proc_o   = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Scoreboard bench: two monitors (HOLD_CYCLES=1 and 4) share one stimulus
// stream. Each stimulus step pushes the hand-derived outputs of both monitors
// after the coming edge; a separate monitor process pops and compares.
module tb_hls_deadlock_param_monitor;

    localparam logic [35:0] MASK = 36'hF00_000_0FF;  // p2=F00, p1=000, p0=0FF
`ifdef DEADLOCK_MON_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    // Stimulus patterns
    localparam int PN  = 0;  // no stall
    localparam int PC  = 1;  // axis[3] (p0), idle=110 -> cond, vec=001
    localparam int PP2 = 2;  // axis[9] (p2), idle=010, iblk=001 -> cond, vec=100
    localparam int PCH = 3;  // axis[0] but child[0]=0 -> no cond

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] axis = '0;
    logic [2:0]  idle = '0, iblk = '0, child = '0;

    logic        b1, s1, b4, s4;
    logic [2:0]  p1, p4;
    logic [15:0] st1, st4;

    typedef struct {
        string       tag;
        logic [20:0] e1;   // {block, sticky, proc[2:0], stall[15:0]}
        logic [20:0] e4;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hls_deadlock_param_monitor #(
        .N_PROC(3), .N_AXIS(12), .AXIS_MASK(MASK), .HOLD_CYCLES(1), .STALL_W(16)
    ) u_h1 (
        .clock_i(clk), .reset_i(rst_n), .axis_block_sigs_i(axis),
        .inst_idle_sigs_i(idle), .inst_block_sigs_i(iblk), .child_block_i(child),
        .clear_i(clr), .block_o(b1), .block_sticky_o(s1),
        .block_proc_o(p1), .stall_cycles_o(st1)
    );

    hls_deadlock_param_monitor #(
        .N_PROC(3), .N_AXIS(12), .AXIS_MASK(MASK), .HOLD_CYCLES(4), .STALL_W(16)
    ) u_h4 (
        .clock_i(clk), .reset_i(rst_n), .axis_block_sigs_i(axis),
        .inst_idle_sigs_i(idle), .inst_block_sigs_i(iblk), .child_block_i(child),
        .clear_i(clr), .block_o(b4), .block_sticky_o(s4),
        .block_proc_o(p4), .stall_cycles_o(st4)
    );

    function automatic logic [20:0] ex(input bit b, input bit s,
                                       input logic [2:0] p, input int st);
        logic [2:0]  pp;
        logic [15:0] ss;
        pp = SNAP ? p : 3'b000;
        ss = SNAP ? 16'(st) : 16'd0;
        return {b, s, pp, ss};
    endfunction

    task automatic step(input string tag, input int pat, input bit c, input bit r,
                        input logic [20:0] e1, input logic [20:0] e4);
        exp_t e;
        @(negedge clk);
        case (pat)
            PC:      begin axis = 12'h008; idle = 3'b110; iblk = 3'b000; child = 3'b111; end
            PP2:     begin axis = 12'h200; idle = 3'b010; iblk = 3'b001; child = 3'b111; end
            PCH:     begin axis = 12'h001; idle = 3'b110; iblk = 3'b000; child = 3'b110; end
            default: begin axis = 12'h000; idle = 3'b110; iblk = 3'b000; child = 3'b111; end
        endcase
        clr   = c;
        rst_n = r;
        e.tag = tag;
        e.e1  = e1;
        e.e4  = e4;
        q.push_back(e);
    endtask

    // Monitor: outputs are sampled 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                cur = q.pop_front();
                n_cmp++;
                if ({b1, s1, p1, st1} !== cur.e1) begin
                    n_bad++;
                    $display("FAIL %s h1: got block=%b sticky=%b proc=%b stall=%0d, want block=%b sticky=%b proc=%b stall=%0d",
                             cur.tag, b1, s1, p1, st1, cur.e1[20], cur.e1[19], cur.e1[18:16], cur.e1[15:0]);
                end
                n_cmp++;
                if ({b4, s4, p4, st4} !== cur.e4) begin
                    n_bad++;
                    $display("FAIL %s h4: got block=%b sticky=%b proc=%b stall=%0d, want block=%b sticky=%b proc=%b stall=%0d",
                             cur.tag, b4, s4, p4, st4, cur.e4[20], cur.e4[19], cur.e4[18:16], cur.e4[15:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        step("reset0", PN, 0, 0, ex(0,0,0,0), ex(0,0,0,0));
        step("reset1", PN, 0, 0, ex(0,0,0,0), ex(0,0,0,0));

        // H=1 detects after one edge; H=4 sees 3 edges then a break
        step("h1_rise",  PC, 0, 1, ex(1,1,3'b001,0), ex(0,0,0,0));
        step("h1_hold1", PC, 0, 1, ex(1,1,3'b001,1), ex(0,0,0,0));
        step("h1_hold2", PC, 0, 1, ex(1,1,3'b001,2), ex(0,0,0,0));
        step("drop1",    PN, 0, 1, ex(0,1,3'b001,3), ex(0,0,0,0));

        // Second run: H=4 asserts only after the 4th consecutive edge
        step("run2_1",   PC, 0, 1, ex(1,1,3'b001,3), ex(0,0,0,0));
        step("run2_2",   PC, 0, 1, ex(1,1,3'b001,4), ex(0,0,0,0));
        step("run2_3",   PC, 0, 1, ex(1,1,3'b001,5), ex(0,0,0,0));
        step("run2_4",   PC, 0, 1, ex(1,1,3'b001,6), ex(1,1,3'b001,0));
        step("drop2",    PN, 0, 1, ex(0,1,3'b001,7), ex(0,1,3'b001,1));

        // Child monitor not qualifying: no deadlock
        for (int i = 0; i < 3; i++)
            step("nochild", PCH, 0, 1, ex(0,1,3'b001,7), ex(0,1,3'b001,1));

        // Clear while DETECTED
        step("pre_clr1", PC, 0, 1, ex(1,1,3'b001,7),  ex(0,1,3'b001,1));
        step("pre_clr2", PC, 0, 1, ex(1,1,3'b001,8),  ex(0,1,3'b001,1));
        step("pre_clr3", PC, 0, 1, ex(1,1,3'b001,9),  ex(0,1,3'b001,1));
        step("pre_clr4", PC, 0, 1, ex(1,1,3'b001,10), ex(1,1,3'b001,1));
        step("pre_clr5", PC, 0, 1, ex(1,1,3'b001,11), ex(1,1,3'b001,2));
        step("clr_det",  PC, 1, 1, ex(1,0,3'b000,0),  ex(1,0,3'b000,0));
        step("post_clr1",PC, 0, 1, ex(1,1,3'b000,1),  ex(1,1,3'b000,1));
        step("post_clr2",PC, 0, 1, ex(1,1,3'b000,2),  ex(1,1,3'b000,2));

        // Clear beats the same-cycle stall increment; then recapture on a new pattern
        step("clr_drop", PN, 1, 1, ex(0,0,3'b000,0),  ex(0,0,3'b000,0));
        step("p2_1",     PP2, 0, 1, ex(1,1,3'b100,0), ex(0,0,3'b000,0));
        step("p2_2",     PP2, 0, 1, ex(1,1,3'b100,1), ex(0,0,3'b000,0));
        step("p2_3",     PP2, 0, 1, ex(1,1,3'b100,2), ex(0,0,3'b000,0));
        step("p2_4",     PP2, 0, 1, ex(1,1,3'b100,3), ex(1,1,3'b100,0));
        step("p2_5",     PP2, 0, 1, ex(1,1,3'b100,4), ex(1,1,3'b100,1));

        // One-cycle reset mid-DETECTED, then the window restarts
        step("rst_det",  PP2, 0, 0, ex(0,0,3'b000,0), ex(0,0,3'b000,0));
        step("rst_re1",  PP2, 0, 1, ex(1,1,3'b100,0), ex(0,0,3'b000,0));
        step("rst_re2",  PP2, 0, 1, ex(1,1,3'b100,1), ex(0,0,3'b000,0));
        step("rst_re3",  PP2, 0, 1, ex(1,1,3'b100,2), ex(0,0,3'b000,0));
        step("rst_re4",  PP2, 0, 1, ex(1,1,3'b100,3), ex(1,1,3'b100,0));

        // Long hold: stall counters saturate at 0xFFFF
        for (int k = 1; k <= 70000; k++)
            step("sat", PP2, 0, 1,
                 ex(1,1,3'b100, (3 + k > 65535) ? 65535 : 3 + k),
                 ex(1,1,3'b100, (k > 65535) ? 65535 : k));
        step("sat_drop", PN, 0, 1, ex(0,1,3'b100,65535), ex(0,1,3'b100,65535));

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_param_monitor.md
# hls_deadlock_param_monitor

Parametrised dataflow deadlock monitor for the PFB decimator's HLS dataflow regions. It generalises the fixed per-region monitors to N processes and M AXI-Stream block sources. It qualifies a candidate deadlock over a programmable persistence window before flagging it. It also latches a sticky flag and a per-process blame snapshot for debug readout.

## Interface
- N_PROC, 3, number of dataflow processes monitored (1..32)
- N_AXIS, 12, number of AXIS block signals (1..64)
- AXIS_MASK, {N_PROC*N_AXIS{1'b0}}, flattened owner map; bit [p*N_AXIS+a] set = AXIS signal a belongs to process p
- HOLD_CYCLES, 1, consecutive qualifying cycles before `block` asserts (1..2^16-1)
- STALL_W, 16, width of saturating stall counter

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- axis_block_sigs  in  N_AXIS  per-stream AXIS blocked
- inst_idle_sigs  in  N_PROC  process idle
- inst_block_sigs  in  N_PROC  process blocked on internal channel
- child_block  in  N_PROC  qualifying block from nested monitor of process p (tie 1 where no nesting)
- clear  in  1  one-cycle pulse; clears sticky/snapshot/stall state
- block  out  1  qualified deadlock, live
- block_sticky  out  1  deadlock seen since last clear
- block_proc  out  N_PROC  axis-blocked process vector captured on detection
- stall_cycles  out  STALL_W  cycles spent in DETECTED since last clear, saturating

## Operation
- axis_vec[p] = child_block[p] & |(axis_block_sigs & AXIS_MASK[p]); a process with an all-zero mask has axis_vec[p]=0.
- stop[p] = inst_idle_sigs[p] | inst_block_sigs[p] | axis_vec[p].
- cond = (|axis_vec) & (&stop), computed combinationally from current inputs.
- FSM states:
  - IDLE: cnt=0. If cond, go to ARMED with cnt=1. If additionally HOLD_CYCLES==1, go directly to DETECTED.
  - ARMED: if !cond, go to IDLE with cnt=0. Otherwise increment cnt; go to DETECTED when cnt+1 == HOLD_CYCLES.
  - DETECTED: `block`=1. If !cond, go to IDLE with cnt=0.
- `block` is registered and is 1 exactly while the state is DETECTED.
- Entry into DETECTED:
  - sets block_sticky;
  - captures axis_vec into block_proc, first entry only, while block_sticky=0.
- stall_cycles increments each cycle the state is DETECTED and saturates at all-ones.
- clear zeroes block_sticky, block_proc and stall_cycles. It has priority over a same-cycle set or increment. The FSM and `block` are unaffected. If the state is still DETECTED, block_sticky re-sets on the next cycle; block_proc is not recaptured until the next entry into DETECTED.
- Reset (reset==0) forces state IDLE and cnt=0. All outputs go to 0 at the next edge, including mid-window and mid-DETECTED.

## Timing
- With HOLD_CYCLES=H: cond is sampled true on H consecutive edges; `block` is high after the H-th edge.
  - H=1 gives the one-cycle registered latency of the existing monitors.
- cond falls, then `block` falls after the next edge.
- One break in cond restarts the window from zero.
- block_sticky and block_proc update on the same edge that `block` rises.
- No handshakes; all inputs are sampled every cycle.

## Configuration
- Macro: DEADLOCK_MON_SNAPSHOT_EN.
- Defined: block_proc and stall_cycles are implemented as described.
- Undefined: the snapshot and counter registers are removed; block_proc and stall_cycles are tied to 0. `block` and block_sticky are unchanged.

## Structure
- Package hls_deadlock_mon_pkg holds:
  - FSM state enum {IDLE, ARMED, DETECTED};
  - HOLD counter width constant (16);
  - mask-slice helper function.
- Sub-module deadlock_persist_counter holds the FSM and the window counter. Its input is cond; its outputs are `block` and the DETECTED entry pulse.
- The top level contains only the combinational vectors, sticky, snapshot and stall registers.

## Test plan
- N_PROC=3, N_AXIS=12, H=1, process masks 0x0FF/0x000/0xF00. Drive axis_block_sigs[3]=1, all children=1, idle=3'b110 -> block=1 one cycle later, block_proc=3'b001.
- H=4: hold cond 3 cycles, drop 1, hold 4 -> block asserts only after the 4th consecutive edge of the second run.
- Hold cond 70000 cycles with STALL_W=16 -> stall_cycles saturates at 0xFFFF.
- Pulse clear while in DETECTED -> block stays 1, block_sticky is 0 for one cycle then returns to 1, block_proc=0, stall_cycles restarts from 0.
- Deassert reset for one cycle while in DETECTED -> all outputs 0 on the next edge; the window restarts.
- child_block[0]=0 while axis_block_sigs[0]=1 and all others stopped -> block stays 0.
